// File: rtl/dac_ctrl_pkg.sv
// Shared definitions for the DAC frame serializer: FSM states, default
// geometry and the frame-length helper.
package dac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA,
    ST_PAD
  } state_t;

  localparam int DEF_NCH   = 12;
  localparam int DEF_LANES = 8;
  localparam int DEF_DW    = 8;
  localparam int DEF_PAD   = 6;
  localparam int DEF_GAP   = 1;
  localparam int GAP_W     = 4;

  // Cycles SYNC is held low: two power-down bits, the data word, the pad.
  function automatic int frame_len(input int dw, input int pad);
    return 2 + dw + pad;
  endfunction

endpackage

// File: rtl/dac_frame_serializer.sv
// Multi-lane DAC frame serializer: one-entry shadow buffer feeding a hold
// register that is shifted out MSB-first on every lane under a low SYNC.
module dac_frame_serializer
  import dac_ctrl_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int PAD   = DEF_PAD,
  parameter int GAP   = DEF_GAP
) (
  input  logic                      SCLK,
  input  logic                      RESET,
  input  logic                      EN,
  input  logic                      CONT,
  input  logic [1:0]                PD,
  input  logic [NCH*LANES*DW-1:0]   DIN,
  input  logic                      DIN_VALID,
  output logic                      DIN_READY,
  output logic [NCH*LANES-1:0]      SDATA,
  output logic                      SYNC,
  output logic                      DONE,
  output logic                      UNDERRUN
);

  localparam int NL = NCH * LANES;
  localparam int WD = NL * DW;
  localparam int CW = $clog2(frame_len(DW, PAD));

  state_t             state_q;
  logic [WD-1:0]      shadow_q;
  logic [WD-1:0]      hold_q;
  logic               shadow_full_q;
  logic               hold_valid_q;
  logic               pd0_q;
  logic [GAP_W-1:0]   gap_q;
  logic [CW-1:0]      bit_cnt_q;
  logic [NL-1:0]      sdata_q;
  logic               sync_q;
  logic               done_q;
  logic               underrun_q;

  logic [NL-1:0]      data_bits;
  logic               capture;
  logic               start;

  assign capture = DIN_VALID & ~shadow_full_q;

  // gap_q counts completed high cycles; the current one makes it >= GAP.
  assign start = EN && (state_q == ST_IDLE) && (gap_q >= GAP_W'(GAP - 1)) &&
                 (shadow_full_q || (CONT && hold_valid_q));

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      localparam int C = gi / LANES;
      localparam int L = gi % LANES;
      logic [DW-1:0] word_shl;
      assign word_shl      = hold_q[(L*NCH+C)*DW +: DW] << bit_cnt_q;
      assign data_bits[gi] = word_shl[DW-1];
    end
  endgenerate

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      shadow_full_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      pd0_q         <= 1'b0;
      gap_q         <= GAP_W'(GAP);
      bit_cnt_q     <= '0;
      sdata_q       <= '0;
      sync_q        <= 1'b1;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;

      // Capture only happens with the shadow empty, so it never races the
      // shadow-to-hold transfer below.
      if (capture) begin
        shadow_q      <= DIN;
        shadow_full_q <= 1'b1;
      end

      if (EN) begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (shadow_full_q) begin
                hold_q        <= shadow_q;
                hold_valid_q  <= 1'b1;
                shadow_full_q <= 1'b0;
              end else begin
                underrun_q <= 1'b1;
              end
              pd0_q     <= PD[0];
              sync_q    <= 1'b0;
              sdata_q   <= {NL{PD[1]}};
              bit_cnt_q <= '0;
              state_q   <= ST_HEAD;
            end else if (gap_q != {GAP_W{1'b1}}) begin
              gap_q <= gap_q + 1'b1;
            end
          end
          ST_HEAD: begin
            sdata_q   <= {NL{pd0_q}};
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
          ST_DATA: begin
            sdata_q <= data_bits;
            if (bit_cnt_q == CW'(DW - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= ST_PAD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          ST_PAD: begin
            sdata_q <= '0;
            if (bit_cnt_q == CW'(PAD)) begin
              sync_q    <= 1'b1;
              done_q    <= 1'b1;
              gap_q     <= '0;
              bit_cnt_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign DIN_READY = ~shadow_full_q;
  assign SDATA     = sdata_q;
  assign SYNC      = sync_q;
  assign DONE      = done_q;
  assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Bench for dac_frame_serializer: directed frame tables plus randomized
// traffic against a frame-position reference model.
module tb_dac_frame_serializer;

  localparam int NCH = 12, LANES = 8, DW = 8, PAD = 6, GAP = 1;
  localparam int NL = NCH * LANES;
  localparam int WDIN = NL * DW;
  localparam int FL = 2 + DW + PAD;

  logic            SCLK = 1'b0;
  logic            RESET, EN, CONT, DIN_VALID, VALID2;
  logic [1:0]      PD;
  logic [WDIN-1:0] DIN;
  logic            DIN_READY, SYNC, DONE, UNDERRUN;
  logic [NL-1:0]   SDATA;
  logic            READY2, SYNC2, DONE2, UNDER2;
  logic [NL-1:0]   SDATA2;

  always #5 SCLK = ~SCLK;

  dac_frame_serializer #(.NCH(NCH), .LANES(LANES), .DW(DW), .PAD(PAD), .GAP(GAP)) u_dut (
    .SCLK(SCLK), .RESET(RESET), .EN(EN), .CONT(CONT), .PD(PD), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .SDATA(SDATA), .SYNC(SYNC),
    .DONE(DONE), .UNDERRUN(UNDERRUN));

  dac_frame_serializer #(.NCH(NCH), .LANES(LANES), .DW(DW), .PAD(PAD), .GAP(3)) u_dut_gap3 (
    .SCLK(SCLK), .RESET(RESET), .EN(EN), .CONT(CONT), .PD(PD), .DIN(DIN),
    .DIN_VALID(VALID2), .DIN_READY(READY2), .SDATA(SDATA2), .SYNC(SYNC2),
    .DONE(DONE2), .UNDERRUN(UNDER2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 0;
  bit en_applied;

  // Reference model: a frame is a position 0..FL-1 under SYNC low.
  logic [WDIN-1:0] m_shadow, m_hold;
  bit              m_full, m_hvalid;
  int              m_pos, m_idle;
  logic [1:0]      m_pd;
  logic            exp_sync, exp_done, exp_under;
  logic [NL-1:0]   exp_sdata;

  function automatic logic [NL-1:0] frame_bits(input int p, input logic [1:0] pd,
                                               input logic [WDIN-1:0] w);
    logic [NL-1:0] r;
    r = '0;
    if (p == 0) r = {NL{pd[1]}};
    else if (p == 1) r = {NL{pd[0]}};
    else if (p < 2 + DW)
      for (int c = 0; c < NCH; c++)
        for (int l = 0; l < LANES; l++)
          r[c*LANES+l] = w[(l*NCH+c)*DW + DW-1-(p-2)];
    return r;
  endfunction

  task automatic model_step();
    bit acc;
    if (RESET) begin
      m_full = 0; m_hvalid = 0; m_pos = -1; m_idle = GAP;
      exp_sync = 1; exp_sdata = '0; exp_done = 0; exp_under = 0;
      return;
    end
    acc = DIN_VALID && !m_full;
    exp_done = 0; exp_under = 0;
    if (EN) begin
      if (m_pos < 0) begin
        if (m_idle >= GAP && (m_full || (CONT && m_hvalid))) begin
          if (m_full) begin
            m_hold = m_shadow; m_full = 0; m_hvalid = 1;
          end else begin
            exp_under = 1;
          end
          m_pd = PD; m_pos = 0; exp_sync = 0;
          exp_sdata = frame_bits(0, m_pd, m_hold);
        end else if (m_idle < 1000) begin
          m_idle++;
        end
      end else begin
        m_pos++;
        if (m_pos == FL) begin
          m_pos = -1; m_idle = 1; exp_sync = 1; exp_sdata = '0; exp_done = 1;
        end else begin
          exp_sdata = frame_bits(m_pos, m_pd, m_hold);
        end
      end
    end
    if (acc) begin
      m_shadow = DIN; m_full = 1;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    en_applied = EN;
    @(posedge SCLK);
    #1;
    cyc++;
    if (chk_on) begin
      n_tests++;
      if ({SYNC, SDATA, DONE, UNDERRUN, DIN_READY} !==
          {exp_sync, exp_sdata, exp_done, exp_under, ~m_full}) begin
        n_fail++;
        $display("FAIL model cyc=%0d actual sync=%b done=%b und=%b rdy=%b sdata=%h required sync=%b done=%b und=%b rdy=%b sdata=%h",
                 cyc, SYNC, DONE, UNDERRUN, DIN_READY, SDATA,
                 exp_sync, exp_done, exp_under, ~m_full, exp_sdata);
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1; DIN_VALID = 0; VALID2 = 0; EN = 1;
    tick(); tick();
    RESET = 0;
  endtask

  function automatic logic [WDIN-1:0] din_const(input logic [7:0] b);
    logic [WDIN-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = b;
    return r;
  endfunction

  function automatic logic [WDIN-1:0] din_pattern(input int base);
    logic [WDIN-1:0] r;
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < LANES; l++)
        r[(l*NCH+c)*DW +: DW] = 8'(base + c*16 + l);
    return r;
  endfunction

  // Frame capture with optional mid-frame hooks keyed by frame bit index.
  int              cap_len, cap_start;
  bit              cap_under, cap_ready_start, cap_done, cap_abort;
  logic [NL-1:0]   cap_bits [FL];
  logic [DW-1:0]   cap_word [NL];
  int              stall_at = -1, load_at = -1, reset_at = -1;
  logic [WDIN-1:0] load_din;

  task automatic capture_frame();
    int k, idx, stall_n;
    logic [NL-1:0] prev_sd;
    cap_abort = 0; cap_done = 0; cap_len = 0; idx = 0; stall_n = 0; k = 0; prev_sd = '0;
    while (SYNC !== 1'b0 && k < 200) begin tick(); k++; end
    if (SYNC !== 1'b0) begin
      check("frame_start", {127'b0, SYNC}, 0);
      return;
    end
    cap_start = cyc; cap_under = UNDERRUN; cap_ready_start = DIN_READY;
    k = 0;
    while (SYNC === 1'b0 && k < 100) begin
      if (en_applied) begin
        if (idx < FL) cap_bits[idx] = SDATA;
        idx++;
      end else begin
        check("stall_hold", SDATA, prev_sd);
      end
      prev_sd = SDATA;
      cap_len++;
      if (en_applied && idx - 1 == reset_at) begin
        RESET = 1; tick(); RESET = 0; cap_abort = 1;
        return;
      end
      if (en_applied && idx - 1 == load_at) begin DIN = load_din; DIN_VALID = 1; end
      if (en_applied && idx - 1 == stall_at) begin EN = 0; stall_n = 4; end
      tick(); k++;
      DIN_VALID = 0;
      if (stall_n > 0) begin
        stall_n--;
        if (stall_n == 0) EN = 1;
      end
    end
    cap_done = DONE;
    for (int g = 0; g < NL; g++)
      for (int b = 0; b < DW; b++)
        cap_word[g][DW-1-b] = cap_bits[2+b][g];
    $display("[TB] frame start=%0d len=%0d under=%b ready=%b done=%b",
             cap_start, cap_len, cap_under, cap_ready_start, cap_done);
  endtask

  function automatic int bad_words(input int base);
    int n;
    n = 0;
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < LANES; l++)
        if (cap_word[c*LANES+l] !== 8'(base + c*16 + l)) n++;
    return n;
  endfunction

  task automatic measure_run2(input logic lvl, output int n);
    n = 0;
    while (SYNC2 === lvl && n < 200) begin tick(); n++; end
  endtask

  typedef struct {
    bit valid;
    bit sync;
    bit sd;
    bit done;
    bit ready;
  } vec_t;

  vec_t tv [22];

  initial begin
    logic [7:0] a5;
    int prev_start, lows, nframes, r;
    a5 = 8'hA5;
    tv[0] = '{1, 1, 0, 0, 0};
    tv[1] = '{0, 0, 1, 0, 1};
    tv[2] = '{0, 0, 0, 0, 1};
    for (int b = 0; b < 8; b++) tv[3+b] = '{0, 0, a5[7-b], 0, 1};
    for (int i = 11; i < 17; i++) tv[i] = '{0, 0, 0, 0, 1};
    tv[17] = '{0, 1, 0, 1, 1};
    for (int i = 18; i < 22; i++) tv[i] = '{0, 1, 0, 0, 1};

    RESET = 1; EN = 0; CONT = 0; PD = 2'b00; DIN = '0; DIN_VALID = 0; VALID2 = 0;
    tick();
    chk_on = 1;
    do_reset();
    check("rst_sync", {127'b0, SYNC}, 1);
    check("rst_sdata", SDATA, 0);
    check("rst_done", {127'b0, DONE}, 0);
    check("rst_underrun", {127'b0, UNDERRUN}, 0);
    check("rst_ready", {127'b0, DIN_READY}, 1);

    // Single triggered frame of 0xA5 with PD=10
    CONT = 0; PD = 2'b10; DIN = din_const(8'hA5);
    for (int i = 0; i < 22; i++) begin
      DIN_VALID = tv[i].valid;
      tick();
      check($sformatf("tv%0d_sync", i), {127'b0, SYNC}, {127'b0, tv[i].sync});
      check($sformatf("tv%0d_sdata", i), SDATA, {NL{tv[i].sd}});
      check($sformatf("tv%0d_done", i), {127'b0, DONE}, {127'b0, tv[i].done});
      check($sformatf("tv%0d_ready", i), {127'b0, DIN_READY}, {127'b0, tv[i].ready});
    end
    $display("[TB] triggered A5 frame table applied");

    // Continuous mode repeating one load
    do_reset();
    CONT = 1; PD = 2'b01; DIN = din_pattern(0); DIN_VALID = 1;
    tick();
    DIN_VALID = 0;
    prev_start = 0;
    for (int f = 1; f <= 3; f++) begin
      capture_frame();
      check($sformatf("cont_len%0d", f), cap_len, FL);
      check($sformatf("cont_under%0d", f), {127'b0, cap_under}, (f > 1) ? 1 : 0);
      check($sformatf("cont_words%0d", f), bad_words(0), 0);
      check($sformatf("cont_done%0d", f), {127'b0, cap_done}, 1);
      if (f > 1) check($sformatf("cont_period%0d", f), cap_start - prev_start, FL + GAP);
      prev_start = cap_start;
    end

    // Shadow refill mid-frame
    do_reset();
    CONT = 1; PD = 2'b11; DIN = din_pattern(0); DIN_VALID = 1;
    tick();
    DIN_VALID = 0;
    load_at = 5; load_din = din_pattern(64);
    capture_frame();
    load_at = -1;
    check("refill_old_words", bad_words(0), 0);
    check("refill_ready_busy", {127'b0, DIN_READY}, 0);
    capture_frame();
    check("refill_new_words", bad_words(64), 0);
    check("refill_no_under", {127'b0, cap_under}, 0);
    check("refill_ready_start", {127'b0, cap_ready_start}, 1);

    // EN stall mid-data
    do_reset();
    CONT = 0; PD = 2'b00; DIN = din_pattern(1); DIN_VALID = 1;
    tick();
    DIN_VALID = 0;
    stall_at = 4;
    capture_frame();
    stall_at = -1;
    check("stall_len", cap_len, FL + 4);
    check("stall_words", bad_words(1), 0);
    check("stall_done", {127'b0, cap_done}, 1);

    // Reset at data bit 3 with a second word waiting in the shadow
    do_reset();
    CONT = 0; PD = 2'b10; DIN = din_pattern(2); DIN_VALID = 1;
    tick();
    DIN_VALID = 0;
    load_at = 3; load_din = din_pattern(3); reset_at = 5;
    capture_frame();
    load_at = -1; reset_at = -1;
    check("abort_seen", {127'b0, cap_abort}, 1);
    check("abort_sync", {127'b0, SYNC}, 1);
    check("abort_sdata", SDATA, 0);
    check("abort_done", {127'b0, DONE}, 0);
    check("abort_ready", {127'b0, DIN_READY}, 1);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (SYNC !== 1'b1) lows++;
    end
    check("abort_no_frame", lows, 0);
    $display("[TB] reset abort sequence applied");

    // GAP=3 instance in continuous mode
    do_reset();
    CONT = 1; PD = 2'b01; DIN = din_pattern(5); VALID2 = 1;
    tick();
    VALID2 = 0;
    measure_run2(1'b1, r);
    for (int f = 0; f < 2; f++) begin
      measure_run2(1'b0, r);
      check($sformatf("gap3_low%0d", f), r, FL);
      measure_run2(1'b1, r);
      check($sformatf("gap3_high%0d", f), r, 3);
    end
    $display("[TB] GAP=3 spacing measured");

    // Randomized traffic against the model
    do_reset();
    nframes = 0;
    for (int i = 0; i < 2500; i++) begin
      EN = ($urandom_range(0, 7) != 0);
      if (i % 64 == 0) CONT = $urandom_range(0, 1);
      PD = 2'($urandom);
      DIN_VALID = ($urandom_range(0, 2) == 0);
      if (DIN_VALID)
        for (int w = 0; w < WDIN / 32; w++) DIN[w*32 +: 32] = $urandom;
      RESET = ($urandom_range(0, 599) == 0);
      tick();
      if (DONE === 1'b1) nframes++;
    end
    RESET = 0; DIN_VALID = 0;
    $display("[TB] random traffic: %0d frames completed", nframes);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
